// File: rtl/ifmap_loader.sv
// IMEM ifmap load transmitter: emits load_start, per-pixel timestep/address/data
// transfers for NUM_TS timesteps, load_done, and the weights-done router packet.
module ifmap_loader #(
    parameter int DEPTH_I    = 25,
    parameter int NUM_TS     = 2,
    parameter int WIDTH_addr = 12,
    parameter int PKT_W      = 33,
    parameter int WDONE_ADDR = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  pix_data,
    output logic                  ls_valid,
    input  logic                  ls_ready,
    output logic                  ls_data,
    output logic                  ts_valid,
    input  logic                  ts_ready,
    output logic [1:0]            ts_data,
    output logic                  ad_valid,
    input  logic                  ad_ready,
    output logic [WIDTH_addr-1:0] ad_data,
    output logic                  dt_valid,
    input  logic                  dt_ready,
    output logic                  dt_data,
    output logic                  ld_valid,
    input  logic                  ld_ready,
    output logic                  ld_data,
    output logic                  rt_valid,
    input  logic                  rt_ready,
    output logic [PKT_W-1:0]      rt_data,
    output logic [3:0]            fsm_state
);

    // Handshake rule for every channel: a transfer happens on the clk edge where
    // valid and ready are both high; valid and data stay stable until then.

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LSTART  = 4'd1,
        FETCH   = 4'd2,
        SEND_TS = 4'd3,
        SEND_AD = 4'd4,
        SEND_DT = 4'd5,
        LDONE   = 4'd6,
        WDONE   = 4'd7,
        FIN     = 4'd8
    } state_t;

    localparam logic [WIDTH_addr-1:0] LAST_ADDR = WIDTH_addr'(DEPTH_I * DEPTH_I - 1);
    localparam logic [1:0]            LAST_TS   = 2'(NUM_TS);
    localparam logic [3:0]            WD_FIELD  = 4'(WDONE_ADDR);
    localparam logic [PKT_W-1:0]      WDONE_PKT = PKT_W'({WD_FIELD, 4'b0000, 25'd0});

    state_t                  state;
    state_t                  state_next;
    logic [1:0]              ts_cnt;
    logic [WIDTH_addr-1:0]   addr_cnt;
    logic                    pix_bit;
    logic                    last_pixel;

    assign last_pixel = (addr_cnt == LAST_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt   <= 2'd1;
            addr_cnt <= '0;
            pix_bit  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (pix_valid) begin
                        pix_bit <= pix_data;
                    end
                end
                SEND_DT: begin
                    // On the final pixel of the final timestep the counters hold; FIN rewinds them.
                    if (dt_ready) begin
                        if (!last_pixel) begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end else if (ts_cnt != LAST_TS) begin
                            addr_cnt <= '0;
                            ts_cnt   <= ts_cnt + 2'd1;
                        end
                    end
                end
                FIN: begin
                    ts_cnt   <= 2'd1;
                    addr_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        pix_ready  = 1'b0;
        ls_valid   = 1'b0;
        ts_valid   = 1'b0;
        ad_valid   = 1'b0;
        dt_valid   = 1'b0;
        ld_valid   = 1'b0;
        rt_valid   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LSTART;
                end
            end
            LSTART: begin
                ls_valid = 1'b1;
                if (ls_ready) state_next = FETCH;
            end
            FETCH: begin
                pix_ready = 1'b1;
                if (pix_valid) state_next = SEND_TS;
            end
            SEND_TS: begin
                ts_valid = 1'b1;
                if (ts_ready) state_next = SEND_AD;
            end
            SEND_AD: begin
                ad_valid = 1'b1;
                if (ad_ready) state_next = SEND_DT;
            end
            SEND_DT: begin
                dt_valid = 1'b1;
                if (dt_ready) begin
                    state_next = (last_pixel && ts_cnt == LAST_TS) ? LDONE : FETCH;
                end
            end
            LDONE: begin
                ld_valid = 1'b1;
                if (ld_ready) state_next = WDONE;
            end
            WDONE: begin
                rt_valid = 1'b1;
                if (rt_ready) state_next = FIN;
            end
            FIN: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Data lines are driven from held registers so they are stable across any stall.
    assign ls_data   = 1'b1;
    assign ld_data   = 1'b1;
    assign ts_data   = ts_cnt;
    assign ad_data   = addr_cnt;
    assign dt_data   = pix_bit;
    assign rt_data   = WDONE_PKT;
    assign fsm_state = state;

endmodule
